// File: rtl/mealy_pkg.sv
// Shared constants and elaboration-time helpers for the Mealy sequence detector family.
package mealy_pkg;

    localparam int unsigned PAT_MAX_W = 16;

    // Longest prefix of pat (first bit at pat[pw-1]) that is a suffix of
    // (first len pattern bits followed by b); capped at pw-1 so a full match
    // is never reported here.
    function automatic int kmp_fallback(input int len, input logic b,
                                        input logic [15:0] pat, input int pw);
        int   res;
        int   j;
        logic ok;
        logic sb;
        res = 0;
        for (int k = 16; k >= 1; k--) begin
            if (res == 0 && k <= len + 1 && k < pw) begin
                ok = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (i < k) begin
                        j  = len + 1 - k + i;
                        sb = (j < len) ? pat[4'(pw - 1 - j)] : b;
                        if (pat[4'(pw - 1 - i)] != sb) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    // Length of the longest proper border of the pattern.
    function automatic int border_len(input logic [15:0] pat, input int pw);
        int   res;
        logic ok;
        res = 0;
        for (int k = 15; k >= 1; k--) begin
            if (res == 0 && k < pw) begin
                ok = 1'b1;
                for (int i = 0; i < 15; i++) begin
                    if (i < k && pat[4'(pw - 1 - i)] != pat[4'(k - 1 - i)]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'(1) << w) - 32'(1));
        return (v >= max_v) ? v : v + 32'(1);
    endfunction

endpackage

// File: rtl/mealy_seq_next.sv
// Combinational next-prefix logic: maps (state, bit, overlap_en) to next state and hit.
module mealy_seq_next
    import mealy_pkg::*;
#(
    parameter int unsigned           PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0]  PATTERN   = 4'b1011,
    parameter int unsigned           ST_W      = $clog2(PATTERN_W)
) (
    input  logic [ST_W-1:0] state,
    input  logic            in_bit,
    input  logic            overlap_en,
    output logic [ST_W-1:0] next_state_c,
    output logic            hit_c
);

    localparam int unsigned NUM_ST  = 1 << ST_W;
    localparam int unsigned BORDER  = int'(border_len(16'(PATTERN), int'(PATTERN_W)));
    localparam logic [ST_W-1:0] LAST_ST = ST_W'(PATTERN_W - 1);

    logic [ST_W-1:0] fb0_tbl [NUM_ST];
    logic [ST_W-1:0] fb1_tbl [NUM_ST];

    // Elaboration-time fallback tables, one entry per prefix length and input bit.
    for (genvar s = 0; s < NUM_ST; s++) begin : g_tbl
        if (s < PATTERN_W) begin : g_used
            assign fb0_tbl[s] = ST_W'(kmp_fallback(s, 1'b0, 16'(PATTERN), int'(PATTERN_W)));
            assign fb1_tbl[s] = ST_W'(kmp_fallback(s, 1'b1, 16'(PATTERN), int'(PATTERN_W)));
        end else begin : g_unused
            assign fb0_tbl[s] = '0;
            assign fb1_tbl[s] = '0;
        end
    end

    // Extend or fall back; on a full match restart at the border or at zero.
    always_comb begin
        hit_c        = (state == LAST_ST) && (in_bit == PATTERN[0]);
        next_state_c = in_bit ? fb1_tbl[state] : fb0_tbl[state];
        if (hit_c) begin
            next_state_c = overlap_en ? ST_W'(BORDER) : '0;
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial pattern detector with overlap control and saturating match counter.
module mealy_seq_detector
    import mealy_pkg::*;
#(
    parameter int unsigned           PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0]  PATTERN   = 4'b1011,
    parameter int unsigned           CNT_W     = 8,
    parameter int unsigned           ST_W      = $clog2(PATTERN_W)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap_en,
    input  logic             clr,
    output logic             match,
    output logic [ST_W-1:0]  state_o,
    output logic [CNT_W-1:0] match_cnt
);

    if (PATTERN_W < 2 || PATTERN_W > PAT_MAX_W) begin : g_bad_width
        $error("mealy_seq_detector: PATTERN_W must be in 2..16");
    end
    if (ST_W < $clog2(PATTERN_W) || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("mealy_seq_detector: ST_W or CNT_W out of range");
    end

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ST_W-1:0]  next_state_c;
    logic             hit_c;

    mealy_seq_next #(
        .PATTERN_W (PATTERN_W),
        .PATTERN   (PATTERN),
        .ST_W      (ST_W)
    ) u_next (
        .state        (state_q),
        .in_bit       (in),
        .overlap_en   (overlap_en),
        .next_state_c (next_state_c),
        .hit_c        (hit_c)
    );

    // State and counter registers; areset wipes any partial match.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: clr beats in_valid; idle cycles hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            state_d = next_state_c;
            if (hit_c) begin
                cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
            end
        end
    end

    // Mealy match output, valid in the same cycle as the final pattern bit.
    always_comb begin
        match = 1'b0;
        if (in_valid && !clr) begin
            match = hit_c;
        end
    end

    assign state_o   = state_q;
    assign match_cnt = cnt_q;

endmodule
